// File: rtl/efuse_load_ctrl.sv
// eFuse load sequencer: reads the fuse macro byte by byte into a shadow array
// after reset or on software request, and serves shadow/status over APB.
module efuse_load_ctrl #(
   parameter int unsigned EFUSE_BIT      = 1024,
   parameter int unsigned APB_ADDR_WIDTH = 8,
   parameter int unsigned APB_DATA_WIDTH = 8,
   parameter int unsigned T_SETUP        = 2,
   parameter int unsigned T_STROBE       = 4
) (
   input  logic                                                     clk,
   input  logic                                                     rstn,
   input  logic                                                     psel,
   input  logic                                                     penable,
   input  logic                                                     pwrite,
   input  logic [APB_ADDR_WIDTH-1:0]                                paddr,
   input  logic [APB_DATA_WIDTH-1:0]                                pwdata,
   output logic [APB_DATA_WIDTH-1:0]                                prdata,
   output logic                                                     pready,
   output logic                                                     pslverr,
   output logic                                                     efuse_csb,
   output logic [$clog2((EFUSE_BIT/8 > 1) ? EFUSE_BIT/8 : 2)-1:0]   efuse_addr,
   output logic                                                     efuse_strobe,
   input  logic [7:0]                                               efuse_dout,
   output logic                                                     busy,
   output logic                                                     load_done
);

   localparam int unsigned N     = EFUSE_BIT / 8;
   localparam int unsigned AW    = $clog2((N > 1) ? N : 2);
   localparam int unsigned TMAX  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
   localparam int unsigned CNT_W = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             auto_q, auto_d;
   logic             reload_q, reload_d;
   logic             done_q, done_d;
   logic             cap_en;
   logic [7:0]       shadow_q [N];

   logic hit_shadow, hit_ctrl, hit_status, access, ctrl_wr;
   logic unused_pwdata;

   assign access     = psel && penable;
   assign hit_shadow = 32'(paddr) < N;
   assign hit_ctrl   = 32'(paddr) == 32'h80;
   assign hit_status = 32'(paddr) == 32'h81;
   assign ctrl_wr    = access && pwrite && hit_ctrl && pwdata[0];
   assign unused_pwdata = ^pwdata;

   assign busy         = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
   assign efuse_csb    = !busy;
   assign efuse_strobe = (state_q == S_STROBE);
   assign efuse_addr   = addr_q;
   assign load_done    = done_q;
   assign pready       = 1'b1;

   // Sequencer state, phase counter, byte address and control flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         auto_q   <= 1'b1;
         reload_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         auto_q   <= auto_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic; a load start clears a reload request raised in the same cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      auto_d   = auto_q;
      reload_d = reload_q;
      done_d   = done_q;
      cap_en   = 1'b0;
      if (ctrl_wr && !busy) begin
         reload_d = 1'b1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (auto_q || reload_q) begin
               auto_d   = 1'b0;
               reload_d = 1'b0;
               done_d   = 1'b0;
               addr_d   = '0;
               cnt_d    = '0;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == CNT_W'(T_SETUP - 1)) begin
               cnt_d   = '0;
               state_d = S_STROBE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STROBE: begin
            if (cnt_q == CNT_W'(T_STROBE - 1)) begin
               cap_en  = 1'b1;
               cnt_d   = '0;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (addr_q == AW'(N - 1)) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = S_SETUP;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Shadow array: cleared on reset, overwritten in place on each strobe capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < N; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (cap_en) begin
         shadow_q[addr_q] <= efuse_dout;
      end
   end

   // APB read mux and error decode, only driven during the access phase.
   always_comb begin
      prdata  = '0;
      pslverr = 1'b0;
      if (access) begin
         if (hit_shadow) begin
            if (pwrite || busy) begin
               pslverr = 1'b1;
            end else begin
               prdata = APB_DATA_WIDTH'(shadow_q[paddr[AW-1:0]]);
            end
         end else if (hit_status) begin
            if (pwrite) begin
               pslverr = 1'b1;
            end else begin
               prdata = APB_DATA_WIDTH'({6'b0, done_q, busy});
            end
         end else if (!hit_ctrl) begin
            pslverr = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_efuse_load_ctrl.sv
// Directed testbench for efuse_load_ctrl with a combinational fuse macro model.
module tb_efuse_load_ctrl;

   localparam int unsigned N    = 128;
   localparam int unsigned LOAD = 897;   // edges from reset release to load_done: 1 + 128*7

   logic       clk;
   logic       rstn;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata, prdata;
   logic       pready, pslverr;
   logic       efuse_csb, efuse_strobe, busy, load_done;
   logic [6:0] efuse_addr;
   logic [7:0] efuse_dout;
   logic       inv;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   efuse_load_ctrl #(
      .EFUSE_BIT      (1024),
      .APB_ADDR_WIDTH (8),
      .APB_DATA_WIDTH (8),
      .T_SETUP        (2),
      .T_STROBE       (4)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .psel         (psel),
      .penable      (penable),
      .pwrite       (pwrite),
      .paddr        (paddr),
      .pwdata       (pwdata),
      .prdata       (prdata),
      .pready       (pready),
      .pslverr      (pslverr),
      .efuse_csb    (efuse_csb),
      .efuse_addr   (efuse_addr),
      .efuse_strobe (efuse_strobe),
      .efuse_dout   (efuse_dout),
      .busy         (busy),
      .load_done    (load_done)
   );

   // Fuse macro: byte k holds k^A5, or ~k once inv is set.
   assign efuse_dout = inv ? ~{1'b0, efuse_addr} : ({1'b0, efuse_addr} ^ 8'hA5);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output logic err);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      #1;
      rd  = prdata;
      err = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int unsigned e = 0;
      while (!load_done && e < 3000) begin
         @(posedge clk); #1;
         e++;
      end
      chk(tag, 32'(load_done), 1);
   endtask

   // Macro interface timing monitor: setup length, strobe width, address stability.
   int unsigned setup_run, strb_run;
   logic        prev_strb, prev_csb_low, addr_bad;
   logic [6:0]  prev_addr, strb_addr;

   always @(negedge clk) begin
      if (!rstn) begin
         setup_run = 0; strb_run = 0; prev_strb = 1'b0; prev_csb_low = 1'b0;
         addr_bad = 1'b0; prev_addr = '0; strb_addr = '0;
      end else begin
         if (efuse_strobe) begin
            if (!prev_strb) begin
               chk("csb_setup", 32'((setup_run >= 2) && !efuse_csb && (efuse_addr == prev_addr)), 1);
               strb_run  = 1;
               strb_addr = efuse_addr;
               addr_bad  = 1'b0;
            end else begin
               strb_run++;
               if (efuse_addr != strb_addr) addr_bad = 1'b1;
            end
         end else begin
            if (prev_strb) begin
               chk("strobe_len", strb_run, 4);
               chk("addr_stable", 32'(addr_bad), 0);
            end
            if (!efuse_csb && prev_csb_low && !prev_strb && efuse_addr == prev_addr) setup_run++;
            else if (!efuse_csb) setup_run = 1;
            else setup_run = 0;
         end
         prev_strb    = efuse_strobe;
         prev_csb_low = !efuse_csb;
         prev_addr    = efuse_addr;
      end
   end

   initial begin
      logic [7:0]  rd;
      logic        er;
      int unsigned e, nb, w;
      logic [6:0]  a_mark;

      rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; inv = 1'b0;

      // Reset values.
      #12;
      chk("rst_csb", 32'(efuse_csb), 1);
      chk("rst_strobe", 32'(efuse_strobe), 0);
      chk("rst_addr", 32'(efuse_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(load_done), 0);
      chk("rst_prdata", 32'(prdata), 0);
      chk("rst_pslverr", 32'(pslverr), 0);
      chk("pready", 32'(pready), 1);
      #10 rstn = 1'b1;

      // Auto load after reset, with APB reads during the load.
      e = 0; nb = 0;
      fork
         begin
            while (!load_done && e < 3000) begin
               @(posedge clk); #1;
               e++;
               if (e == 1) begin
                  chk("busy_rise", 32'(busy), 1);
                  chk("csb_first", 32'(efuse_csb), 0);
               end
               if (busy) nb++;
            end
         end
         begin
            repeat (60) @(posedge clk);
            apb_xfer(1'b0, 8'h10, 8'h00, rd, er);
            chk("busy_shadow_data", 32'(rd), 0);
            chk("busy_shadow_err", 32'(er), 1);
            apb_xfer(1'b0, 8'h81, 8'h00, rd, er);
            chk("status_busy", 32'(rd), 32'h01);
            chk("status_busy_err", 32'(er), 0);
         end
      join
      chk("load_edges", e, LOAD);
      chk("busy_cycles", nb, N * 7);
      chk("load_done", 32'(load_done), 1);
      chk("busy_fall", 32'(busy), 0);

      apb_xfer(1'b0, 8'h81, 8'h00, rd, er);
      chk("status_done", 32'(rd), 32'h02);
      apb_xfer(1'b0, 8'h05, 8'h00, rd, er);
      chk("rd05", 32'(rd), 32'hA0);
      chk("rd05_err", 32'(er), 0);
      apb_xfer(1'b0, 8'h00, 8'h00, rd, er);
      chk("rd00", 32'(rd), 32'hA5);
      apb_xfer(1'b0, 8'h7F, 8'h00, rd, er);
      chk("rd7f", 32'(rd), 32'hDA);

      // Reload with inverted macro data; CTRL write mid-load is ignored.
      inv = 1'b1;
      apb_xfer(1'b1, 8'h80, 8'h01, rd, er);
      chk("ctrl_wr_err", 32'(er), 0);
      w = 0;
      while (!busy && w < 5) begin
         @(posedge clk); #1;
         w++;
      end
      chk("reload_busy", 32'(busy), 1);
      chk("reload_done_low", 32'(load_done), 0);
      w = 0;
      while (efuse_addr != 7'd20 && w < 1000) begin
         @(posedge clk); #1;
         w++;
      end
      a_mark = efuse_addr;
      apb_xfer(1'b1, 8'h80, 8'h01, rd, er);
      chk("ctrl_busy_err", 32'(er), 0);
      chk("no_restart", 32'(efuse_addr >= a_mark && efuse_addr != 0), 1);
      wait_done("reload_done");
      repeat (10) @(posedge clk);
      #1;
      chk("no_extra_load", 32'(busy), 0);
      apb_xfer(1'b0, 8'h00, 8'h00, rd, er);
      chk("rd00_inv", 32'(rd), 32'hFF);
      apb_xfer(1'b0, 8'h05, 8'h00, rd, er);
      chk("rd05_inv", 32'(rd), 32'hFA);

      // Reset during byte 40 aborts the load and clears the shadow.
      inv = 1'b0;
      apb_xfer(1'b1, 8'h80, 8'h01, rd, er);
      w = 0;
      while (efuse_addr != 7'd40 && w < 1000) begin
         @(posedge clk); #1;
         w++;
      end
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b0;
      #2;
      chk("abort_csb", 32'(efuse_csb), 1);
      chk("abort_strobe", 32'(efuse_strobe), 0);
      chk("abort_addr", 32'(efuse_addr), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(load_done), 0);
      apb_xfer(1'b0, 8'h00, 8'h00, rd, er);
      chk("abort_sh00", 32'(rd), 0);
      apb_xfer(1'b0, 8'h05, 8'h00, rd, er);
      chk("abort_sh05", 32'(rd), 0);
      #3 rstn = 1'b1;
      @(posedge clk); #1;
      chk("restart_busy", 32'(busy), 1);
      chk("restart_addr", 32'(efuse_addr), 0);
      wait_done("restart_done");
      apb_xfer(1'b0, 8'h28, 8'h00, rd, er);
      chk("rd28", 32'(rd), 32'h8D);

      // Illegal accesses.
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h90;
      #1;
      chk("setup_phase_err", 32'(pslverr), 0);
      chk("setup_phase_data", 32'(prdata), 0);
      psel = 1'b0;
      apb_xfer(1'b1, 8'h03, 8'h55, rd, er);
      chk("wr_shadow_err", 32'(er), 1);
      apb_xfer(1'b0, 8'h90, 8'h00, rd, er);
      chk("rd90_err", 32'(er), 1);
      chk("rd90_data", 32'(rd), 0);
      apb_xfer(1'b0, 8'hFF, 8'h00, rd, er);
      chk("rdff_err", 32'(er), 1);
      chk("rdff_data", 32'(rd), 0);
      apb_xfer(1'b1, 8'h81, 8'h03, rd, er);
      chk("wr_status_err", 32'(er), 1);
      apb_xfer(1'b0, 8'h80, 8'h00, rd, er);
      chk("rd_ctrl_data", 32'(rd), 0);
      chk("rd_ctrl_err", 32'(er), 0);
      apb_xfer(1'b0, 8'h03, 8'h00, rd, er);
      chk("rd03_kept", 32'(rd), 32'hA6);
      chk("rd03_err", 32'(er), 0);
      chk("idle_after_errs", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
